// File: rtl/i2c_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : i2c_reg_slave
// Description : Oversampled I2C slave that turns host transfers into one-cycle
//               register-bus write/read strobes for the SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h2A,
    parameter int         FILT_LEN   = 3
) (
    input  logic       i_ck,
    input  logic       i_rstn,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic [3:0] o_address,
    output logic [7:0] o_data,
    input  logic [7:0] i_data,
    output logic       o_wr,
    output logic       o_rd
);
    localparam int            CW         = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] C_FILT_MAX = CW'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WDATA,
        S_WDATA_ACK, S_RFETCH, S_RDATA, S_RACK, S_IGNORE
    } state_t;

    // Index 0 carries SCL, index 1 carries SDA through the input path.
    logic [1:0]         sync1_q, sync2_q, filt_q, filt_d, prev_q;
    logic [1:0][CW-1:0] cnt_q, cnt_d;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic [3:0] ptr_q, ptr_d;
    logic       oe_q, oe_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [1:0] fetch_q, fetch_d;

    logic       scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
    logic [7:0] byte_w;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            cnt_d[i]  = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == C_FILT_MAX) filt_d[i] = sync2_q[i];
                else                        cnt_d[i]  = cnt_q[i] + 1'b1;
            end
        end
    end

    assign scl_f    = filt_q[0];
    assign sda_f    = filt_q[1];
    assign scl_rise = scl_f & ~prev_q[0];
    assign scl_fall = ~scl_f & prev_q[0];
    assign start_c  = scl_f & prev_q[0] & prev_q[1] & ~sda_f;
    assign stop_c   = scl_f & prev_q[0] & ~prev_q[1] & sda_f;
    assign byte_w   = {shift_q[6:0], sda_f};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        fetch_d   = {fetch_q[0], 1'b0};
        // Read data is captured two cycles after the strobe, once the register bus has answered.
        if (fetch_q[1]) tx_d = i_data;

        if (start_c) begin
            state_d   = S_ADDR;
            oe_d      = 1'b0;
            bit_cnt_d = '0;
        end else if (stop_c) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_w;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == S_ADDR) begin
                                if (byte_w[7:1] != SLAVE_ADDR) begin
                                    state_d = S_IGNORE;
                                end else begin
                                    rw_d    = byte_w[0];
                                    state_d = S_ADDR_ACK;
                                    if (byte_w[0]) begin
                                        rd_d    = 1'b1;
                                        addr_d  = ptr_q;
                                        fetch_d = 2'b01;
                                    end
                                end
                            end else if (state_q == S_PTR) begin
                                ptr_d   = byte_w[3:0];
                                state_d = S_PTR_ACK;
                            end else begin
                                data_d  = byte_w;
                                addr_d  = ptr_q;
                                wr_d    = 1'b1;
                                ptr_d   = ptr_q + 4'd1;
                                state_d = S_WDATA_ACK;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    // bit_cnt marks whether the 9th rise has been seen yet.
                    if (scl_rise) bit_cnt_d = 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == S_ADDR_ACK && rw_q) begin
                                state_d = S_RDATA;
                                oe_d    = ~tx_q[7];
                                tx_d    = {tx_q[6:0], 1'b0};
                            end else if (state_q == S_ADDR_ACK) begin
                                state_d = S_PTR;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d      = 1'b0;
                            ptr_d     = ptr_q + 4'd1;
                            bit_cnt_d = '0;
                            state_d   = S_RACK;
                        end else begin
                            oe_d = ~tx_q[7];
                            tx_d = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                S_RACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = '0;
                        state_d   = sda_f ? S_IGNORE : S_RFETCH;
                    end
                end
                S_RFETCH: begin
                    rd_d    = 1'b1;
                    addr_d  = ptr_q;
                    fetch_d = 2'b01;
                    state_d = S_RDATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            filt_q    <= 2'b11;
            prev_q    <= 2'b11;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            rw_q      <= 1'b0;
            ptr_q     <= '0;
            oe_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            fetch_q   <= '0;
        end else begin
            sync1_q   <= {i_sda, i_scl};
            sync2_q   <= sync1_q;
            filt_q    <= filt_d;
            prev_q    <= filt_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            fetch_q   <= fetch_d;
        end
    end

    assign o_sda_oe  = oe_q;
    assign o_wr      = wr_q;
    assign o_rd      = rd_q;
    assign o_address = addr_q;
    assign o_data    = data_q;
endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_reg_slave
// Description : Randomized I2C master driving i2c_reg_slave, with a register
//               device model and a strobe scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_reg_slave;
    localparam logic [6:0] C_SA = 7'h2A;
    localparam int         C_H  = 24;

    logic       i_ck = 1'b0;
    logic       i_rstn = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       i_scl, i_sda, o_sda_oe, o_wr, o_rd;
    logic [3:0] o_address;
    logic [7:0] o_data;
    logic [7:0] i_data = 8'h00;

    assign i_scl = m_scl;
    assign i_sda = m_sda & ~o_sda_oe;

    always #5 i_ck = ~i_ck;

    i2c_reg_slave #(.SLAVE_ADDR(C_SA), .FILT_LEN(3)) u_dut (
        .i_ck(i_ck), .i_rstn(i_rstn), .i_scl(i_scl), .i_sda(i_sda),
        .o_sda_oe(o_sda_oe), .o_address(o_address), .o_data(o_data),
        .i_data(i_data), .o_wr(o_wr), .o_rd(o_rd)
    );

    typedef struct packed {
        logic       is_wr;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [16] = '{default: 8'h00};
    logic [7:0] dev [16] = '{default: 8'h00};
    int         mptr = 0;
    bit         quiet = 1'b0;
    int         glitch_bit = -1;
    logic [3:0] last_addr = 4'h0;
    logic [7:0] last_data = 8'h00;

    // Downstream register device: read data appears the cycle after o_rd.
    always @(posedge i_ck) begin
        if (o_wr) dev[o_address] <= o_data;
        if (o_rd) i_data <= dev[o_address];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        ev_t  e;
        logic pwr = 1'b0;
        logic prd = 1'b0;
        forever begin
            @(negedge i_ck);
            if (!i_rstn) begin
                pwr = 1'b0;
                prd = 1'b0;
            end else begin
                if (o_wr || o_rd) check("strobe_exclusive", o_wr & o_rd, 0);
                if (quiet && o_sda_oe) check("ignored_sda_oe", o_sda_oe, 0);
                if (o_wr) begin
                    check("wr_width", pwr, 0);
                    check("wr_expected", sb.size() != 0, 1);
                    if (!pwr && sb.size() != 0) begin
                        e = sb.pop_front();
                        check("wr_kind", 1, e.is_wr);
                        check("wr_addr", o_address, e.addr);
                        check("wr_data", o_data, e.data);
                    end
                end
                if (o_rd) begin
                    check("rd_width", prd, 0);
                    check("rd_expected", sb.size() != 0, 1);
                    if (!prd && sb.size() != 0) begin
                        e = sb.pop_front();
                        check("rd_kind", 0, e.is_wr);
                        check("rd_addr", o_address, e.addr);
                    end
                end
                pwr = o_wr;
                prd = o_rd;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge i_ck);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        cyc(C_H / 2); m_sda = b; cyc(C_H / 2); m_scl = 1'b1;
        if (glitch) begin
            cyc(C_H / 2); m_sda = ~b; cyc(1); m_sda = b; cyc(C_H / 2 - 1);
        end else begin
            cyc(C_H);
        end
        m_scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        cyc(C_H / 2); m_sda = 1'b1; cyc(C_H / 2); m_scl = 1'b1;
        cyc(C_H / 2); b = i_sda; cyc(C_H / 2); m_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string nm);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(d[i], glitch_bit == i);
        recv_bit(a);
        check(nm, a, exp_ack);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic nack);
        logic [7:0] d;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        check("read_byte", d, exp);
        send_bit(nack, 1'b0);
    endtask

    task automatic start_cond;
        if (!m_scl) begin
            cyc(C_H / 2); m_sda = 1'b1; cyc(C_H / 2); m_scl = 1'b1; cyc(C_H);
        end
        m_sda = 1'b0; cyc(C_H); m_scl = 1'b0;
    endtask

    task automatic stop_cond;
        cyc(C_H / 2); m_sda = 1'b0; cyc(C_H / 2); m_scl = 1'b1;
        cyc(C_H); m_sda = 1'b1; cyc(C_H);
    endtask

    // Reference model: a matching write sets the pointer, then each data byte
    // lands at the pointer which then advances modulo 16.
    task automatic m_write(input logic [6:0] a7, input logic [3:0] p, input logic [7:0] d[$], input bit stop);
        bit hit;
        hit = (a7 == C_SA);
        start_cond;
        write_byte({a7, 1'b0}, !hit, "addr_ack");
        write_byte({4'($urandom), p}, !hit, "ptr_ack");
        if (hit) mptr = int'(p);
        foreach (d[i]) begin
            if (hit) begin
                sb.push_back('{is_wr: 1'b1, addr: 4'(mptr), data: d[i]});
                mem[mptr] = d[i];
                last_addr = 4'(mptr);
                last_data = d[i];
                mptr = (mptr + 1) % 16;
            end
            write_byte(d[i], !hit, "wdata_ack");
        end
        if (stop) stop_cond;
    endtask

    task automatic m_read(input int n);
        logic [7:0] exp;
        start_cond;
        sb.push_back('{is_wr: 1'b0, addr: 4'(mptr), data: 8'h00});
        write_byte({C_SA, 1'b1}, 1'b0, "raddr_ack");
        for (int k = 0; k < n; k++) begin
            exp  = mem[mptr];
            mptr = (mptr + 1) % 16;
            if (k < n - 1) sb.push_back('{is_wr: 1'b0, addr: 4'(mptr), data: 8'h00});
            read_byte(exp, k == n - 1);
        end
        stop_cond;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] noq[$];
        int         t;

        #3;
        check("rst_sda_oe", o_sda_oe, 0);
        check("rst_wr", o_wr, 0);
        check("rst_rd", o_rd, 0);
        check("rst_address", o_address, 0);
        check("rst_data", o_data, 0);
        cyc(4);
        @(negedge i_ck) i_rstn = 1'b1;
        cyc(C_H);

        q = {};
        q.push_back(8'h5A); q.push_back(8'h3C);
        m_write(C_SA, 4'h1, q, 1'b1);
        check("hold_address", o_address, last_addr);
        check("hold_data", o_data, last_data);

        q = {};
        q.push_back(8'h81); q.push_back(8'h7E);
        m_write(C_SA, 4'h3, q, 1'b1);
        m_write(C_SA, 4'h3, noq, 1'b0);
        m_read(2);
        m_read(1);

        quiet = 1'b1;
        q = {};
        q.push_back(8'($urandom)); q.push_back(8'($urandom));
        m_write(7'h2B, 4'h5, q, 1'b1);
        quiet = 1'b0;

        m_write(C_SA, 4'h9, noq, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
        stop_cond;
        check("partial_sda_oe", o_sda_oe, 0);
        m_read(1);

        q = {};
        q.push_back(8'($urandom)); q.push_back(8'($urandom));
        m_write(C_SA, 4'hF, q, 1'b1);
        m_write(C_SA, 4'hF, noq, 1'b1);
        m_read(2);

        glitch_bit = 3;
        q = {};
        q.push_back(8'($urandom)); q.push_back(8'($urandom));
        m_write(C_SA, 4'($urandom), q, 1'b1);
        glitch_bit = -1;
        m_read(3);

        start_cond;
        for (int i = 7; i >= 0; i--) send_bit(((C_SA << 1) >> i) & 1, 1'b0);
        t = 0;
        while (!o_sda_oe && t < 100) begin
            cyc(1);
            t++;
        end
        check("ack_drive_before_reset", o_sda_oe, 1);
        #2 i_rstn = 1'b0;
        #1 check("async_reset_sda_oe", o_sda_oe, 0);
        mptr = 0;
        m_scl = 1'b1;
        m_sda = 1'b1;
        cyc(5);
        @(negedge i_ck) i_rstn = 1'b1;
        cyc(C_H);
        m_read(1);

        for (int r = 0; r < 6; r++) begin
            logic [6:0] a;
            int         n;
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, 3);
                q = {};
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                a = ($urandom_range(0, 5) == 0) ? (C_SA ^ 7'($urandom_range(1, 127))) : C_SA;
                m_write(a, 4'($urandom), q, 1'b1);
            end else begin
                m_read($urandom_range(1, 3));
            end
        end

        cyc(50);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
